// File: rtl/instruction_fetcher_pkg.sv
// Shared front-end definitions: width defaults, RISC-V major opcodes and the
// fetch FSM state encoding. Used by the fetcher, instruction queue and decoder.
package instruction_fetcher_pkg;

    localparam int IFU_INST_WIDTH = 32;
    localparam int IFU_ADDR_WIDTH = 17;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PUSH    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Sequential next-PC computation. With IFU_JAL_PREDICT_EN defined, JAL
// instructions redirect fetch to pc + J-immediate; otherwise always pc + 4.
module fetch_next_pc
    import instruction_fetcher_pkg::*;
#(
    parameter int INST_WIDTH = IFU_INST_WIDTH,
    parameter int ADDR_WIDTH = IFU_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] next_pc
);

`ifdef IFU_JAL_PREDICT_EN
    logic [20:0]           j_imm;
    logic [ADDR_WIDTH-1:0] j_imm_ext;
    logic                  unused_rd;

    assign j_imm     = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    // Signed cast sign-extends or truncates to the PC width as needed.
    assign j_imm_ext = ADDR_WIDTH'($signed(j_imm));
    assign next_pc   = (inst[6:0] == OPC_JAL) ? pc + j_imm_ext : pc + ADDR_WIDTH'(4);
    assign unused_rd = ^inst[11:7];
`else
    logic unused_inst;

    assign next_pc     = pc + ADDR_WIDTH'(4);
    assign unused_inst = ^inst;
`endif

endmodule

// File: rtl/instruction_fetcher.sv
// Front-end fetch stage: one outstanding fetch, pushes {pc, inst} to the
// instruction queue, honours back-end redirects. Option: IFU_JAL_PREDICT_EN.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int                    INST_WIDTH = IFU_INST_WIDTH,
    parameter int                    ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rdy,
    output logic                             mem_req_valid,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    input  logic                             mem_req_ready,
    input  logic                             mem_resp_valid,
    input  logic [INST_WIDTH-1:0]            mem_resp_data,
    output logic                             inst_queue_entry_valid,
    output logic [ADDR_WIDTH+INST_WIDTH-1:0] inst_queue_entry,
    input  logic                             inst_queue_ready,
    input  logic                             redirect_valid,
    input  logic [ADDR_WIDTH-1:0]            redirect_addr
);

    fetch_state_t          state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n, next_pc;
    logic [INST_WIDTH-1:0] inst, inst_n;
    logic                  unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_addr[1:0];

    fetch_next_pc #(
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_pc (
        .pc      (pc),
        .inst    (inst),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
            pc    <= RESET_ADDR;
            inst  <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            inst  <= inst_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst;
        if (rdy) begin
            if (redirect_valid) begin
                // A redirect wins; an in-flight request becomes stale and
                // must be drained in DISCARD before the next fetch goes out.
                pc_n = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
                unique case (state)
                    ST_REQ:     state_n = mem_req_ready  ? ST_DISCARD : ST_REQ;
                    ST_WAIT:    state_n = mem_resp_valid ? ST_REQ     : ST_DISCARD;
                    ST_PUSH:    state_n = ST_REQ;
                    ST_DISCARD: state_n = mem_resp_valid ? ST_REQ     : ST_DISCARD;
                    default:    state_n = ST_REQ;
                endcase
            end else begin
                unique case (state)
                    ST_REQ: if (mem_req_ready) state_n = ST_WAIT;
                    ST_WAIT: if (mem_resp_valid) begin
                        inst_n  = mem_resp_data;
                        state_n = ST_PUSH;
                    end
                    ST_PUSH: if (inst_queue_ready) begin
                        pc_n    = next_pc;
                        state_n = ST_REQ;
                    end
                    ST_DISCARD: if (mem_resp_valid) state_n = ST_REQ;
                    default: state_n = ST_REQ;
                endcase
            end
        end
    end

    assign mem_req_valid          = (state == ST_REQ);
    assign mem_req_addr           = pc;
    assign inst_queue_entry_valid = (state == ST_PUSH);
    assign inst_queue_entry       = (state == ST_PUSH) ? {pc, inst} : '0;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed cycle table, reset
// sequences, and a randomized run against a transaction-level fetch model.
module tb_instruction_fetcher;

    localparam int AW = 17;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [AW-1:0] mem_req_addr, redirect_addr;
    logic [IW-1:0] mem_resp_data;
    logic          inst_queue_entry_valid, inst_queue_ready, redirect_valid;
    logic [AW+IW-1:0] inst_queue_entry;

    instruction_fetcher dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .mem_req_valid          (mem_req_valid),
        .mem_req_addr           (mem_req_addr),
        .mem_req_ready          (mem_req_ready),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_data          (mem_resp_data),
        .inst_queue_entry_valid (inst_queue_entry_valid),
        .inst_queue_entry       (inst_queue_entry),
        .inst_queue_ready       (inst_queue_ready),
        .redirect_valid         (redirect_valid),
        .redirect_addr          (redirect_addr)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W0  = 32'h0000_0013;
    localparam logic [31:0] W1  = 32'h0010_0093;
    localparam logic [31:0] W2  = 32'hDEAD_BEEF;
    localparam logic [31:0] W3  = 32'h0020_8133;
    localparam logic [31:0] W4  = 32'h1234_5678;
    localparam logic [31:0] W5  = 32'h0000_0073;
    localparam logic [31:0] JAL = 32'hFF9F_F06F;  // jal x0, -8
`ifdef IFU_JAL_PREDICT_EN
    localparam logic [AW-1:0] JAL_TGT = 17'h00018;
`else
    localparam logic [AW-1:0] JAL_TGT = 17'h00024;
`endif

    typedef struct {
        logic          rdy, mrr, rv;
        logic [IW-1:0] rd;
        logic          qr, redv;
        logic [AW-1:0] reda;
        logic          erv;
        logic [AW-1:0] ea;
        logic          eev;
        logic [AW-1:0] epc;
        logic [IW-1:0] einst;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;
    int row   = 0;

    function automatic vec_t mk(logic r, logic mrr, logic rv, logic [IW-1:0] rd,
                                logic qr, logic redv, logic [AW-1:0] reda,
                                logic erv, logic [AW-1:0] ea,
                                logic eev, logic [AW-1:0] epc, logic [IW-1:0] einst);
        vec_t v;
        v.rdy = r; v.mrr = mrr; v.rv = rv; v.rd = rd; v.qr = qr; v.redv = redv;
        v.reda = reda; v.erv = erv; v.ea = ea; v.eev = eev; v.epc = epc; v.einst = einst;
        return v;
    endfunction

    task automatic add(logic r, logic mrr, logic rv, logic [IW-1:0] rd,
                       logic qr, logic redv, logic [AW-1:0] reda,
                       logic erv, logic [AW-1:0] ea,
                       logic eev, logic [AW-1:0] epc, logic [IW-1:0] einst);
        vecs.push_back(mk(r, mrr, rv, rd, qr, redv, reda, erv, ea, eev, epc, einst));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic cyc(input vec_t v);
        @(negedge clk);
        rdy = v.rdy; mem_req_ready = v.mrr; mem_resp_valid = v.rv; mem_resp_data = v.rd;
        inst_queue_ready = v.qr; redirect_valid = v.redv; redirect_addr = v.reda;
        #1;
        chk("req_valid", 64'(mem_req_valid), 64'(v.erv));
        if (v.erv) chk("req_addr", 64'(mem_req_addr), 64'(v.ea));
        chk("entry_valid", 64'(inst_queue_entry_valid), 64'(v.eev));
        if (v.eev) chk("entry", 64'(inst_queue_entry), 64'({v.epc, v.einst}));
        row++;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        inst_queue_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory contents: a hash of the address, with a JAL planted every 8 words.
    function automatic logic [31:0] word(input logic [AW-1:0] a);
        logic [31:0] h;
        h = ({15'd0, a} * 32'h9E37_79B1) ^ 32'h1234_5677;
        if (a[4:2] == 3'd5) return {h[31:22], 1'b0, h[20:12], 5'd0, 7'h6F};
        return {h[31:22], 1'b0, h[20:0]};
    endfunction

    function automatic logic [AW-1:0] ref_next(input logic [AW-1:0] pc, input logic [31:0] w);
`ifdef IFU_JAL_PREDICT_EN
        if (w[6:0] == 7'h6F) begin
            int imm;
            imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            return AW'(int'(pc) + imm);
        end
`endif
        return AW'(int'(pc) + 4);
    endfunction

    initial begin
        rst = 1'b1;
        idle_inputs();

        // sequential fetch, one entry per 3 cycles
        add(1,1,0,0,  0,0,0,        1,0,       0,0,0);
        add(1,0,1,W0, 0,0,0,        0,0,       0,0,0);
        add(1,0,0,0,  1,0,0,        0,0,       1,0,W0);
        add(1,1,0,0,  0,0,0,        1,4,       0,0,0);
        add(1,0,1,W1, 0,0,0,        0,0,       0,0,0);
        // queue backpressure: entry held, no new request even with mem ready
        for (int i = 0; i < 5; i++) add(1,1,0,0, 0,0,0, 0,0, 1,4,W1);
        add(1,0,0,0,  1,0,0,        0,0,       1,4,W1);
        add(1,0,0,0,  0,0,0,        1,8,       0,0,0);
        add(1,1,0,0,  0,0,0,        1,8,       0,0,0);
        // redirect in WAIT, stale response dropped
        add(1,0,0,0,  0,1,17'h103,  0,0,       0,0,0);
        add(1,0,1,W2, 0,0,0,        0,0,       0,0,0);
        add(1,1,0,0,  0,0,0,        1,17'h100, 0,0,0);
        add(1,0,1,W3, 0,0,0,        0,0,       0,0,0);
        // redirect in PUSH with ready high: not pushed
        add(1,0,0,0,  1,1,17'h20,   0,0,       1,17'h100,W3);
        add(1,1,0,0,  0,0,0,        1,17'h20,  0,0,0);
        add(1,0,1,JAL,0,0,0,        0,0,       0,0,0);
        add(1,0,0,0,  1,0,0,        0,0,       1,17'h20,JAL);
        add(1,0,0,0,  0,0,0,        1,JAL_TGT, 0,0,0);
        // wrap at top of address space
        add(1,0,0,0,  0,1,17'h1FFFC,1,JAL_TGT, 0,0,0);
        add(1,1,0,0,  0,0,0,        1,17'h1FFFC,0,0,0);
        add(1,0,1,W4, 0,0,0,        0,0,       0,0,0);
        add(1,0,0,0,  1,0,0,        0,0,       1,17'h1FFFC,W4);
        add(1,0,0,0,  0,0,0,        1,0,       0,0,0);
        // rdy low freezes REQ, WAIT, PUSH and DISCARD despite active inputs
        for (int i = 0; i < 3; i++) add(0,1,1,W5, 1,1,17'h500, 1,0, 0,0,0);
        add(1,1,0,0,  0,0,0,        1,0,       0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,1,W5, 1,1,17'h500, 0,0, 0,0,0);
        add(1,0,1,W5, 0,0,0,        0,0,       0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,1,W2, 1,1,17'h500, 0,0, 1,0,W5);
        add(1,0,0,0,  1,0,0,        0,0,       1,0,W5);
        add(1,1,0,0,  0,0,0,        1,4,       0,0,0);
        add(1,0,0,0,  0,1,17'h40,   0,0,       0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,1,W2, 1,1,17'h500, 0,0, 0,0,0);
        add(1,0,0,0,  0,1,17'h80,   0,0,       0,0,0);
        add(1,0,1,W2, 0,0,0,        0,0,       0,0,0);
        // redirect with handshake in REQ, then with response in WAIT
        add(1,1,0,0,  0,1,17'hC0,   1,17'h80,  0,0,0);
        add(1,0,1,W2, 0,0,0,        0,0,       0,0,0);
        add(1,0,0,0,  0,0,0,        1,17'hC0,  0,0,0);
        add(1,1,0,0,  0,0,0,        1,17'hC0,  0,0,0);
        add(1,0,1,W2, 0,1,17'hE0,   0,0,       0,0,0);
        add(1,0,0,0,  0,0,0,        1,17'hE0,  0,0,0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_req_valid", 64'(mem_req_valid), 64'd1);
        chk("reset_req_addr", 64'(mem_req_addr), 64'd0);
        chk("reset_entry_valid", 64'(inst_queue_entry_valid), 64'd0);
        chk("reset_entry", 64'(inst_queue_entry), 64'd0);

        foreach (vecs[i]) cyc(vecs[i]);

        // reset while WAIT; a late response must not be taken
        cyc(mk(1,1,0,0, 0,0,0, 1,17'hE0, 0,0,0));
        reset_dut();
        cyc(mk(1,0,1,W2, 0,0,0, 1,0, 0,0,0));
        chk("midrst_entry", 64'(inst_queue_entry), 64'd0);
        cyc(mk(1,0,0,0, 0,0,0, 1,0, 0,0,0));
        cyc(mk(1,0,0,0, 1,0,0, 1,0, 0,0,0));

        // randomized run against a transaction-level model
        reset_dut();
        begin
            logic [AW-1:0] exp_pc, paddr;
            logic          pend;
            int            cnt, idle, pushes;
            exp_pc = '0; pend = 1'b0; cnt = 0; idle = 0; pushes = 0;
            for (int c = 0; c < 6000; c++) begin
                @(negedge clk);
                rdy              = ($urandom_range(7) != 0);
                mem_req_ready    = $urandom_range(1) == 1;
                inst_queue_ready = ($urandom_range(3) != 0);
                redirect_valid   = ($urandom_range(31) == 0);
                redirect_addr    = AW'($urandom);
                mem_resp_valid   = pend && cnt == 0 && rdy;
                mem_resp_data    = mem_resp_valid ? word(paddr) : $urandom;
                #1;
                if (rdy && mem_req_valid && mem_req_ready) begin
                    chk("rand_one_outstanding", 64'(pend), 64'd0);
                    if (!redirect_valid) chk("rand_req_addr", 64'(mem_req_addr), 64'(exp_pc));
                end
                if (rdy && inst_queue_entry_valid && inst_queue_ready && !redirect_valid) begin
                    chk("rand_entry", 64'(inst_queue_entry), 64'({exp_pc, word(exp_pc)}));
                    exp_pc = ref_next(exp_pc, word(exp_pc));
                    pushes++;
                    idle = 0;
                end else begin
                    idle++;
                end
                if (rdy && redirect_valid) exp_pc = {redirect_addr[AW-1:2], 2'b00};
                if (mem_resp_valid) pend = 1'b0;
                else if (pend && cnt > 0) cnt--;
                if (rdy && mem_req_valid && mem_req_ready) begin
                    pend = 1'b1; paddr = mem_req_addr; cnt = $urandom_range(2);
                end
                if (idle > 400) begin
                    chk("rand_progress_timeout", 64'(idle), 64'd0);
                    break;
                end
            end
            chk("rand_enough_pushes", 64'(pushes > 200), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Front-end fetch stage of the out-of-order RISC-V core. Holds the program counter, issues one 32-bit instruction fetch at a time to the memory/icache port, and pushes `{pc, instruction}` entries into the instruction queue. It supports redirects from the back end (branch/jump resolution) and discards an in-flight response made stale by a redirect.

## Interface
Parameters:
- `INST_WIDTH`, 32, instruction width.
- `ADDR_WIDTH`, 17, PC/memory address width.
- `RESET_ADDR`, 0, PC value after reset.

Ports:
- `clk`  in  1  clock, one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; when low, all state is frozen.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_addr`  out  ADDR_WIDTH  fetch address (word aligned).
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_resp_valid`  in  1  fetched word valid (one-cycle pulse).
- `mem_resp_data`  in  INST_WIDTH  fetched instruction.
- `inst_queue_entry_valid`  out  1  queue push valid.
- `inst_queue_entry`  out  ADDR_WIDTH+INST_WIDTH  `{pc, inst}`, pc in the MSBs.
- `inst_queue_ready`  in  1  queue can accept an entry.
- `redirect_valid`  in  1  back end forces a new PC.
- `redirect_addr`  in  ADDR_WIDTH  new PC; bits [1:0] are ignored and treated as 0.

## Operation
FSM states:
- **REQ:** `mem_req_valid`=1 and `mem_req_addr`=pc. On `mem_req_ready`, go to WAIT.
- **WAIT:** on `mem_resp_valid`, latch `mem_resp_data` into the inst register and go to PUSH.
- **PUSH:** `inst_queue_entry_valid`=1 and `inst_queue_entry`={pc, inst}. On `inst_queue_ready`, set pc←next_pc and go to REQ.
- **DISCARD:** no outputs asserted. On `mem_resp_valid`, drop the data and go to REQ.

Rules:
- At most one outstanding memory request.
- next_pc = (pc + 4) mod 2^ADDR_WIDTH, unless modified as described under Configuration.
- Redirect has priority over every other event. In any state, pc←{redirect_addr[ADDR_WIDTH-1:2], 2'b00}, and then:
  - REQ with handshake in the same cycle → DISCARD.
  - REQ without handshake → REQ (the new address appears next cycle).
  - WAIT with no response this cycle → DISCARD.
  - WAIT with response this cycle → REQ (the response is dropped).
  - PUSH → REQ. The entry is not pushed, even if `inst_queue_ready`=1 in that cycle.
  - DISCARD without response → DISCARD (pc is updated).
  - DISCARD with response → REQ (the response is dropped).
- `rdy`=0 freezes pc, state and the inst register. Outputs hold their current values. Inputs are ignored, including redirect.

## Timing
- Reset values: state=REQ, pc=RESET_ADDR, inst=0. `mem_req_valid` is 1 in the first cycle after reset, with `mem_req_addr`=RESET_ADDR. `inst_queue_entry_valid`=0 and `inst_queue_entry`=0.
- Reset in mid-operation aborts any request. A memory response arriving after reset is ignored unless the FSM is in WAIT by then.
- Latency from request handshake to queue push: response latency + 1 cycle. `inst_queue_entry_valid` rises the cycle after `mem_resp_valid`.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, PUSH), assuming single-cycle ready and response.
- In PUSH, `inst_queue_entry_valid` and the entry are stable until accepted or redirected. The push completes in the cycle where valid && ready.
- The queue's ready may go low while full. The block stalls in PUSH with no loss or duplication.
- pc wraps from 2^ADDR_WIDTH−4 to 0.

## Configuration
- Macro: `IFU_JAL_PREDICT_EN`.
- **Defined:** when the accepted entry's opcode is 7'b1101111 (JAL), next_pc = pc + J-immediate. The J-immediate is {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, sign-extended, with the sum truncated to ADDR_WIDTH. All other opcodes use pc+4.
- **Undefined:** next_pc is always pc+4. JAL targets arrive only via redirect.

## Structure
- Shared package holds:
  - width constants (INST_WIDTH, ADDR_WIDTH);
  - RISC-V opcode constants, shared with the instruction queue and decoder;
  - the FSM state encoding.
- One combinational sub-module, `fetch_next_pc`, computes next_pc from (pc, inst). It contains the `IFU_JAL_PREDICT_EN` logic.

## Test plan
- **Sequential fetch:** reset, 1-cycle memory latency, queue always ready, ADDR_WIDTH=17 → requests to 0x0, 0x4, 0x8. Entries are {0x0, word0}, {0x4, word1}, …, one every 3 cycles.
- **Queue backpressure:** hold `inst_queue_ready`=0 for 5 cycles in PUSH → entry held stable, no new `mem_req_valid`. Exactly one push after ready rises.
- **Redirect during WAIT:** redirect to 0x103 in WAIT → stale response discarded. Next request is to 0x100, and no entry is pushed for the old pc.
- **Redirect in PUSH with ready=1:** → no push that cycle. Next request is to the redirect address.
- **Wrap and rdy:** pc=0x1FFFC → next request is to 0x0. Toggling `rdy`=0 for 3 cycles in each state freezes all outputs.
- **`IFU_JAL_PREDICT_EN`:** JAL with imm −8 at pc 0x20 → next request is to 0x18. With the macro undefined, next request is to 0x24.
